// File: rtl/vproc_pkg.sv
// ============================================================================
// Module : vproc_pkg
// Shared constants and types for the vector micro-op splitter and consumers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vproc_pkg;

  localparam int VREG_W        = 5;
  localparam int UOP_PAYLOAD_W = 32;
  localparam int UOP_IDX_W     = 3;

  typedef logic [1:0] emul_log2_t;

  typedef struct packed {
    logic [UOP_PAYLOAD_W-1:0] payload;
    logic [VREG_W-1:0]        vd;
    logic [VREG_W-1:0]        vs1;
    logic [VREG_W-1:0]        vs2;
    logic [UOP_IDX_W-1:0]     idx;
    logic                     first;
    logic                     last;
  } uop_split_t;

endpackage

`default_nettype wire

// File: rtl/vproc_uop_splitter.sv
// ============================================================================
// Module : vproc_uop_splitter
// Expands register-group vector instructions into one micro-op per register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vproc_uop_splitter
  import vproc_pkg::*;
#(
  parameter int PAYLOAD_W     = 32,
  parameter int MAX_EMUL_LOG2 = 3
) (
  input  logic                 clk_i,
  input  logic                 async_rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [VREG_W-1:0]    in_vd_i,
  input  logic [VREG_W-1:0]    in_vs1_i,
  input  logic [VREG_W-1:0]    in_vs2_i,
  input  emul_log2_t           in_emul_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [VREG_W-1:0]    out_vd_o,
  output logic [VREG_W-1:0]    out_vs1_o,
  output logic [VREG_W-1:0]    out_vs2_o,
  output logic [2:0]           out_idx_o,
  output logic                 out_first_o,
  output logic                 out_last_o,
  output logic                 busy_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SPLIT = 1'b1;

  localparam emul_log2_t c_max_emul = emul_log2_t'(MAX_EMUL_LOG2);

  logic [0:0]           r_state;
  logic [2:0]           r_idx;
  emul_log2_t           r_emul;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [VREG_W-1:0]    r_vd;
  logic [VREG_W-1:0]    r_vs1;
  logic [VREG_W-1:0]    r_vs2;

  logic       w_valid;
  logic       w_fire;
  logic       w_last;
  logic       w_accept;
  logic [2:0] w_last_idx;
  emul_log2_t w_emul_clamped;

  assign w_emul_clamped = (in_emul_i > c_max_emul) ? c_max_emul : in_emul_i;
  assign w_last_idx     = 3'((4'd1 << r_emul) - 4'd1);

  assign w_valid  = (r_state == S_SPLIT);
  assign w_last   = w_valid && (r_idx == w_last_idx);
  assign w_fire   = w_valid && out_ready_i;
  // Reload on the final handshake so consecutive groups stream without a bubble.
  assign w_accept = in_valid_i && in_ready_o;

  assign in_ready_o    = (r_state == S_IDLE) || (w_fire && w_last);
  assign out_valid_o   = w_valid;
  assign busy_o        = w_valid;
  assign out_payload_o = r_payload;
  assign out_vd_o      = r_vd  + {2'b00, r_idx};
  assign out_vs1_o     = r_vs1 + {2'b00, r_idx};
  assign out_vs2_o     = r_vs2 + {2'b00, r_idx};
  assign out_idx_o     = r_idx;
  assign out_first_o   = w_valid && (r_idx == 3'd0);
  assign out_last_o    = w_last;

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_emul    <= '0;
      r_payload <= '0;
      r_vd      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
    end else if (w_accept) begin
      r_state   <= S_SPLIT;
      r_idx     <= '0;
      r_emul    <= w_emul_clamped;
      r_payload <= in_payload_i;
      r_vd      <= in_vd_i;
      r_vs1     <= in_vs1_i;
      r_vs2     <= in_vs2_i;
    end else if (w_fire) begin
      if (w_last) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire
